buzz_arbiter: RTL and testbench

- Shares the single piezo `buzz` output between game sound requesters: fire, enemy hit, stage clear, and boss entry.
- Each requester pulses a one-cycle request. The block latches it, arbitrates by fixed priority and plays that requester's tone for its duration.
- A mandatory silent gap is inserted between sounds.
- Sits between the game logic (bullet/enemy/stage controllers) and the top-level `buzz` pin, replacing the direct `fire_sound` hookup.

---
 rtl/sound_pkg.sv | 26 ++
 rtl/tone_gen.sv | 46 ++++
 rtl/buzz_arbiter.sv | 155 +++++++++++++++
 tb/tb_buzz_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants, default tone tables and FSM states for buzz_arbiter
// Purpose: requester indices, default half-period/duration tables (4 requesters),
//          FSM state encoding and the tone counter width.
// Ports:   none (package).
package sound_pkg;

  localparam int SND_HIT   = 0;
  localparam int SND_CLEAR = 1;
  localparam int SND_BOSS  = 2;
  localparam int SND_FIRE  = 3;

  localparam int TONE_W = 16;
  localparam int DUR_W  = 8;

  // Entry i lives at [16*i +: 16]: hit 1 kHz, clear 1.32 kHz, boss 500 Hz, fire 2 kHz.
  localparam logic [4*TONE_W-1:0] HALF_PER_DEF = {16'd6250, 16'd25000, 16'd9470, 16'd12500};
  // Entry i lives at [8*i +: 8], in ms ticks.
  localparam logic [4*DUR_W-1:0]  DUR_DEF      = {8'd30, 8'd200, 8'd250, 8'd80};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator with half-period counter and load/clear control
// Purpose: counts 0..half-1 and toggles tone at each wrap; half <= 1 toggles every cycle.
// Ports:   clk25, rst_n (sync active-low); load latches half_in and restarts at tone = 0;
//          clear stops at tone = 0; run advances the counter; tone is the square wave.
module tone_gen
  import sound_pkg::*;
(
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              run,
  input  logic [TONE_W-1:0] half_in,
  output logic              tone
);

  logic [TONE_W-1:0] half_q;
  logic [TONE_W-1:0] cnt;
  logic              wrap;

  // Degenerate half-periods of 0 or 1 wrap every cycle.
  assign wrap = (half_q <= TONE_W'(1)) || (cnt >= half_q - TONE_W'(1));

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      half_q <= '0;
      cnt    <= '0;
      tone   <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (load) begin
      half_q <= half_in;
      cnt    <= '0;
      tone   <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + TONE_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzz_arbiter.sv
// rtl/buzz_arbiter.sv - fixed-priority arbiter sharing one piezo output between sound requesters
// Purpose: latches one-cycle requests, grants the lowest index, plays its tone for its
//          duration with preemption by higher priority, then inserts a silent gap.
// Ports:   clk25 system clock; rst_n sync active-low reset; buzz_en enable (0 = mute+flush);
//          req one-cycle request pulses; buzz piezo drive; busy high in PLAY/GAP;
//          active_id current requester (valid while playing); playing high in PLAY.
module buzz_arbiter
  import sound_pkg::*;
#(
  parameter int                      N_REQ         = 4,
  parameter int                      TICK_DIV      = 25000,
  parameter int                      GAP_TICKS     = 4,
  parameter logic [16*N_REQ-1:0]     HALF_PER_FLAT = HALF_PER_DEF,
  parameter logic [8*N_REQ-1:0]      DUR_FLAT      = DUR_DEF
)(
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             buzz_en,
  input  logic [N_REQ-1:0] req,
  output logic             buzz,
  output logic             busy,
  output logic [1:0]       active_id,
  output logic             playing
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t             state, state_nx;
  logic [N_REQ-1:0]   pending, pending_nx, cand, grant_mask;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [DUR_W-1:0]   dur_cnt, dur_nx, dur_sel;
  logic [GW-1:0]      gap_cnt, gap_nx;
  logic [1:0]         id_q, winner;
  logic               any_cand, preempt, grant;
  logic               tone_clear, tone_run;
  logic [TONE_W-1:0]  half_sel;

  // Same-cycle requests take part in arbitration so a pulse can be granted without first
  // sitting in pending.
  assign cand = pending | req;

  always_comb begin
    winner   = 2'd0;
    any_cand = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner   = 2'(i);
        any_cand = 1'b1;
      end
    end
  end

  assign grant_mask = N_REQ'(1) << winner;
  assign half_sel   = HALF_PER_FLAT[16*int'(winner) +: 16];
  assign dur_sel    = DUR_FLAT[8*int'(winner) +: 8];
  // winner is the lowest set index, so anything more urgent than the active sound shows here.
  assign preempt    = any_cand && (winner < id_q);
  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    state_nx   = state;
    pending_nx = pending | req;
    dur_nx     = dur_cnt;
    gap_nx     = gap_cnt;
    grant      = 1'b0;
    tone_clear = 1'b0;
    tone_run   = 1'b0;

    if (!buzz_en) begin
      state_nx   = IDLE;
      pending_nx = '0;
      dur_nx     = '0;
      gap_nx     = '0;
      tone_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            grant    = 1'b1;
            state_nx = PLAY;
          end
        end
        PLAY: begin
          if (preempt) begin
            grant = 1'b1;
          end else if (dur_cnt == '0 || (tick && dur_cnt == DUR_W'(1))) begin
            // Leaving on the tick that would reach zero makes PLAY exactly DUR ticks long.
            state_nx   = GAP;
            dur_nx     = '0;
            gap_nx     = '0;
            tone_clear = 1'b1;
          end else begin
            tone_run = 1'b1;
            if (tick) dur_nx = dur_cnt - DUR_W'(1);
          end
        end
        GAP: begin
          if (GAP_TICKS == 0) begin
            state_nx = IDLE;
          end else if (tick) begin
            if (gap_cnt == GW'(GAP_TICKS - 1)) begin
              state_nx = IDLE;
              gap_nx   = '0;
            end else begin
              gap_nx = gap_cnt + GW'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase

      // Grant beats a same-cycle request from the winner: its pending bit ends cleared.
      if (grant) begin
        pending_nx = cand & ~grant_mask;
        dur_nx     = dur_sel;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      tick_cnt <= '0;
      id_q     <= 2'd0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      dur_cnt  <= dur_nx;
      gap_cnt  <= gap_nx;
      // Restarting the tick phase on grant keeps durations exact to one clk25 cycle.
      tick_cnt <= (grant || tick) ? '0 : tick_cnt + TW'(1);
      if (grant) id_q <= winner;
    end
  end

  tone_gen u_tone (
    .clk25   (clk25),
    .rst_n   (rst_n),
    .load    (grant),
    .clear   (tone_clear),
    .run     (tone_run),
    .half_in (half_sel),
    .tone    (buzz)
  );

  assign busy      = (state != IDLE);
  assign playing   = (state == PLAY);
  assign active_id = id_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// tb/tb_buzz_arbiter.sv - directed self-checking bench for buzz_arbiter
module tb_buzz_arbiter;

  logic       clk25   = 1'b0;
  logic       rst_n   = 1'b0;
  logic       buzz_en = 1'b0;
  logic [3:0] req     = 4'b0000;
  logic       buzz, busy, playing;
  logic [1:0] active_id;

  int tests  = 0;
  int failed = 0;

  always #20 clk25 = ~clk25;

  buzz_arbiter #(
    .N_REQ         (4),
    .TICK_DIV      (10),
    .GAP_TICKS     (2),
    .HALF_PER_FLAT ({16'd3, 16'd6, 16'd5, 16'd4}),
    .DUR_FLAT      ({8'd2, 8'd4, 8'd3, 8'd5})
  ) dut (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .buzz_en   (buzz_en),
    .req       (req),
    .buzz      (buzz),
    .busy      (busy),
    .active_id (active_id),
    .playing   (playing)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_playing", {7'd0, playing}, 8'd0);
    chk("rst_buzz", {7'd0, buzz}, 8'd0);
    chk("rst_id", {6'd0, active_id}, 8'd0);

    // Fire alone: half 3, 20 play cycles, 20 gap cycles
    rst_n = 1'b1; buzz_en = 1'b1; req = 4'b1000;
    cyc(1);
    req = 4'b0000;
    chk("s1_id", {6'd0, active_id}, 8'd3);
    for (int c = 0; c < 20; c++) begin
      chk("s1_playing", {7'd0, playing}, 8'd1);
      chk("s1_buzz", {7'd0, buzz}, 8'((c / 3) % 2));
      cyc(1);
    end
    for (int g = 0; g < 20; g++) begin
      chk("s1_gap_busy", {7'd0, busy}, 8'd1);
      chk("s1_gap_playing", {7'd0, playing}, 8'd0);
      chk("s1_gap_buzz", {7'd0, buzz}, 8'd0);
      cyc(1);
    end
    chk("s1_idle_busy", {7'd0, busy}, 8'd0);

    // Clear and fire together: clear first (30), gap, idle, fire (20), gap, idle
    req = 4'b1010;
    cyc(1);
    req = 4'b0000;
    chk("s2_first_id", {6'd0, active_id}, 8'd1);
    chk("s2_first_buzz", {7'd0, buzz}, 8'd0);
    cyc(29);
    chk("s2_last_play", {7'd0, playing}, 8'd1);
    chk("s2_last_id", {6'd0, active_id}, 8'd1);
    cyc(1);
    chk("s2_gap_playing", {7'd0, playing}, 8'd0);
    chk("s2_gap_busy", {7'd0, busy}, 8'd1);
    cyc(20);
    chk("s2_idle_busy", {7'd0, busy}, 8'd0);
    cyc(1);
    chk("s2_second_play", {7'd0, playing}, 8'd1);
    chk("s2_second_id", {6'd0, active_id}, 8'd3);
    cyc(20);
    chk("s2_second_gap", {7'd0, playing}, 8'd0);
    cyc(20);
    chk("s2_end_busy", {7'd0, busy}, 8'd0);
    cyc(10);
    chk("s2_no_more", {7'd0, busy}, 8'd0);

    // Boss preempted by hit 7 cycles in; hit plays 50 cycles; boss never resumes
    req = 4'b0100;
    cyc(1);
    req = 4'b0000;
    chk("s3_boss_id", {6'd0, active_id}, 8'd2);
    cyc(7);
    chk("s3_boss_buzz", {7'd0, buzz}, 8'd1);
    req = 4'b0001;
    cyc(1);
    req = 4'b0000;
    chk("s3_pre_id", {6'd0, active_id}, 8'd0);
    chk("s3_pre_playing", {7'd0, playing}, 8'd1);
    chk("s3_pre_buzz", {7'd0, buzz}, 8'd0);
    cyc(4);
    chk("s3_hit_buzz", {7'd0, buzz}, 8'd1);
    cyc(45);
    chk("s3_hit_last", {7'd0, playing}, 8'd1);
    chk("s3_hit_last_id", {6'd0, active_id}, 8'd0);
    cyc(1);
    chk("s3_hit_gap", {7'd0, playing}, 8'd0);
    cyc(20);
    chk("s3_idle", {7'd0, busy}, 8'd0);
    cyc(30);
    chk("s3_no_resume", {7'd0, busy}, 8'd0);

    // Three fire pulses during one clear playback coalesce to one fire playback
    req = 4'b0010;
    cyc(1);
    for (int c = 0; c < 30; c++) begin
      req = (c == 2 || c == 5 || c == 10) ? 4'b1000 : 4'b0000;
      chk("s4_clear_id", {6'd0, active_id}, 8'd1);
      cyc(1);
    end
    req = 4'b0000;
    chk("s4_gap", {7'd0, playing}, 8'd0);
    cyc(20);
    chk("s4_idle", {7'd0, busy}, 8'd0);
    cyc(1);
    chk("s4_fire_play", {7'd0, playing}, 8'd1);
    chk("s4_fire_id", {6'd0, active_id}, 8'd3);
    cyc(40);
    chk("s4_after", {7'd0, busy}, 8'd0);
    cyc(15);
    chk("s4_only_once", {7'd0, busy}, 8'd0);

    // buzz_en drop mid-play with boss pending flushes everything
    req = 4'b0010;
    cyc(1);
    req = 4'b0100;
    cyc(1);
    req = 4'b0000;
    cyc(4);
    chk("s5_buzz_before", {7'd0, buzz}, 8'd1);
    chk("s5_id_before", {6'd0, active_id}, 8'd1);
    buzz_en = 1'b0;
    cyc(1);
    chk("s5_mute_buzz", {7'd0, buzz}, 8'd0);
    chk("s5_mute_busy", {7'd0, busy}, 8'd0);
    buzz_en = 1'b1;
    cyc(3);
    chk("s5_no_play", {7'd0, playing}, 8'd0);
    cyc(30);
    chk("s5_still_idle", {7'd0, busy}, 8'd0);

    // Reset mid-gap with hit pending
    req = 4'b1000;
    cyc(1);
    req = 4'b0000;
    cyc(20);
    req = 4'b0001;
    cyc(1);
    req = 4'b0000;
    chk("s6_gap_busy", {7'd0, busy}, 8'd1);
    chk("s6_gap_playing", {7'd0, playing}, 8'd0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("s6_rst_busy", {7'd0, busy}, 8'd0);
    chk("s6_rst_playing", {7'd0, playing}, 8'd0);
    chk("s6_rst_buzz", {7'd0, buzz}, 8'd0);
    chk("s6_rst_id", {6'd0, active_id}, 8'd0);
    cyc(40);
    chk("s6_no_play", {7'd0, playing}, 8'd0);
    chk("s6_idle", {7'd0, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
